intc_pic: RTL and testbench

INTC_PIC -- requirements
Module: intc_pic

---
 rtl/intc_pic.sv | 105 ++++++++++
 tb/tb_intc_pic.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/intc_pic.sv
`default_nettype none
// ============================================================================
// Module      : intc_pic
// Description : Fixed-priority programmable interrupt controller, edge/level
//               per channel, with IMR/ELCR/base/command port interface.
// Revision    : 1.0 - initial release
// ============================================================================
module intc_pic #(
    parameter int         NUM_IRQ   = 8,
    parameter logic [7:0] BASE_PORT = 8'h20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [7:0]         port_i,
    input  logic [7:0]         data_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               inta_i,
    output logic               int_o,
    output logic [7:0]         vector_o,
    output logic [31:0]        int_status
);

    localparam logic [7:0] c_RST_BASE = 8'h08;
    localparam logic [7:0] c_CMD_NSEOI = 8'h20;
    localparam logic [7:0] c_SPUR_OFS = 8'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] r_imr, r_elcr, r_irr, r_isr, r_irq_prev;
    logic [7:0]         r_base;
    logic               r_int;
    logic [7:0]         r_vector;

    logic [7:0]         w_off;
    logic [NUM_IRQ-1:0] w_pend, w_edge, w_irr_nxt;
    logic [NUM_IRQ-1:0] w_imr_nxt, w_elcr_nxt, w_ack_mask, w_eoi_mask;
    logic [3:0]         w_win, w_srv;
    logic               w_req, w_ack, w_cmd, w_nseoi, w_speoi;

    // Lowest set bit wins; scanning downward leaves the lowest index last.
    function automatic logic [3:0] f_lowest(input logic [NUM_IRQ-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    assign w_off   = port_i - BASE_PORT;
    assign w_pend  = r_irr & ~r_imr;
    assign w_win   = f_lowest(w_pend);
    assign w_srv   = f_lowest(r_isr);
    assign w_req   = (|w_pend) && (!(|r_isr) || (w_win < w_srv));
    assign w_ack   = inta_i && r_int && (|w_pend);
    assign w_cmd   = we_i && (w_off == 8'd5);
    assign w_nseoi = w_cmd && (data_i == c_CMD_NSEOI);
    assign w_speoi = w_cmd && (data_i[7:4] == 4'h6);
    assign w_edge  = irq_i & ~r_irq_prev;

    // A fresh edge re-arms an edge channel even while it is being acknowledged.
    assign w_irr_nxt = (r_elcr & irq_i) | (~r_elcr & ((r_irr & ~w_ack_mask) | w_edge));

    always_comb begin
        w_imr_nxt  = r_imr;
        w_elcr_nxt = r_elcr;
        w_ack_mask = '0;
        w_eoi_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (we_i && (w_off == ((i < 8) ? 8'd0 : 8'd1))) w_imr_nxt[i]  = data_i[i % 8];
            if (we_i && (w_off == ((i < 8) ? 8'd2 : 8'd3))) w_elcr_nxt[i] = data_i[i % 8];
            if (w_ack && (w_win == 4'(i)))                   w_ack_mask[i] = 1'b1;
            if (w_nseoi && (|r_isr) && (w_srv == 4'(i)))     w_eoi_mask[i] = 1'b1;
            if (w_speoi && (data_i[3:0] == 4'(i)))           w_eoi_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_imr      <= '1;
            r_elcr     <= '0;
            r_base     <= c_RST_BASE;
            r_irr      <= '0;
            r_isr      <= '0;
            r_irq_prev <= '0;
            r_int      <= 1'b0;
            r_vector   <= 8'h00;
        end else begin
            r_imr      <= w_imr_nxt;
            r_elcr     <= w_elcr_nxt;
            if (we_i && (w_off == 8'd4)) r_base <= data_i;
            r_irq_prev <= irq_i;
            r_irr      <= w_irr_nxt;
            // EOI acts on the pre-cycle ISR; the acknowledge is merged afterwards.
            r_isr      <= (r_isr & ~w_eoi_mask) | w_ack_mask;
            r_int      <= w_req && !w_ack;
            if (inta_i) r_vector <= w_ack ? (r_base + 8'(w_win)) : (r_base + c_SPUR_OFS);
        end
    end

    assign int_o      = r_int;
    assign vector_o   = r_vector;
    assign int_status = {16'(r_isr), 16'(r_irr)};

endmodule
`default_nettype wire

// File: tb/tb_intc_pic.sv
`default_nettype none
// ============================================================================
// Module      : tb_intc_pic
// Description : Directed self-checking bench for intc_pic (8- and 16-channel).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intc_pic;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [7:0]  port = 8'h00;
    logic [7:0]  data = 8'h00;
    logic        inta = 1'b0;
    logic [7:0]  irq8 = '0;
    logic [15:0] irq16 = '0;
    logic        int8, int16;
    logic [7:0]  vec8, vec16;
    logic [31:0] st8, st16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    intc_pic #(.NUM_IRQ(8), .BASE_PORT(8'h20)) u_dut8 (
        .clk(clk), .rst(rst), .we_i(we), .port_i(port), .data_i(data),
        .irq_i(irq8), .inta_i(inta), .int_o(int8), .vector_o(vec8), .int_status(st8)
    );

    intc_pic #(.NUM_IRQ(16), .BASE_PORT(8'h20)) u_dut16 (
        .clk(clk), .rst(rst), .we_i(we), .port_i(port), .data_i(data),
        .irq_i(irq16), .inta_i(inta), .int_o(int16), .vector_o(vec16), .int_status(st16)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        we = 1'b1; port = p; data = d;
        tick();
        we = 1'b0;
    endtask

    task automatic do_reset;
        irq8 = '0; irq16 = '0; inta = 1'b0; we = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL rst_int: got %b want 0", int8); end
        n_tests++; if (vec8 !== 8'h00) begin n_fail++; $display("FAIL rst_vec: got %h want 00", vec8); end
        n_tests++; if (st8 !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0", st8); end
        irq8 = 8'h01;
        tick(); tick();
        n_tests++; if (st8 !== 32'h0000_0001) begin n_fail++; $display("FAIL rst_masked_irr: got %h want 00000001", st8); end
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL rst_masked_int: got %b want 0", int8); end
    endtask

    task automatic test_basic;
        do_reset();
        wr(8'h20, 8'hFE);
        irq8 = 8'h01;
        tick();
        n_tests++; if (st8 !== 32'h0000_0001) begin n_fail++; $display("FAIL basic_irr: got %h want 00000001", st8); end
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL basic_int_early: got %b want 0", int8); end
        tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL basic_int: got %b want 1", int8); end
        irq8 = 8'h00; inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec8 !== 8'h08) begin n_fail++; $display("FAIL basic_vec: got %h want 08", vec8); end
        n_tests++; if (st8 !== 32'h0001_0000) begin n_fail++; $display("FAIL basic_status: got %h want 00010000", st8); end
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL basic_int_after_ack: got %b want 0", int8); end
    endtask

    task automatic test_nested;
        do_reset();
        wr(8'h20, 8'h00);
        irq8 = 8'h08;
        tick(); tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec8 !== 8'h0B) begin n_fail++; $display("FAIL nest_vec3: got %h want 0B", vec8); end
        irq8 = 8'h28;
        tick(); tick(); tick();
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL nest_low_blocked: got %b want 0", int8); end
        irq8 = 8'h2A;
        tick(); tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL nest_high_int: got %b want 1", int8); end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec8 !== 8'h09) begin n_fail++; $display("FAIL nest_vec1: got %h want 09", vec8); end
        n_tests++; if (st8 !== 32'h000A_0020) begin n_fail++; $display("FAIL nest_status: got %h want 000A0020", st8); end
        wr(8'h25, 8'h20);
        n_tests++; if (st8 !== 32'h0008_0020) begin n_fail++; $display("FAIL nest_nseoi: got %h want 00080020", st8); end
        wr(8'h25, 8'h63);
        n_tests++; if (st8 !== 32'h0000_0020) begin n_fail++; $display("FAIL nest_seoi: got %h want 00000020", st8); end
        tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL nest_reassert: got %b want 1", int8); end
    endtask

    task automatic test_level;
        do_reset();
        wr(8'h24, 8'h40);
        wr(8'h22, 8'h04);
        wr(8'h20, 8'hFB);
        irq8 = 8'h04;
        tick(); tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL lvl_int: got %b want 1", int8); end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec8 !== 8'h42) begin n_fail++; $display("FAIL lvl_vec: got %h want 42", vec8); end
        n_tests++; if (st8 !== 32'h0004_0004) begin n_fail++; $display("FAIL lvl_status: got %h want 00040004", st8); end
        tick();
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL lvl_in_service: got %b want 0", int8); end
        wr(8'h25, 8'h20);
        n_tests++; if (st8 !== 32'h0000_0004) begin n_fail++; $display("FAIL lvl_eoi: got %h want 00000004", st8); end
        tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL lvl_reassert: got %b want 1", int8); end
    endtask

    task automatic test_spurious;
        do_reset();
        irq8 = 8'h04;
        tick(); tick();
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec8 !== 8'h0F) begin n_fail++; $display("FAIL spur_vec: got %h want 0F", vec8); end
        n_tests++; if (st8 !== 32'h0000_0004) begin n_fail++; $display("FAIL spur_status: got %h want 00000004", st8); end
    endtask

    task automatic test_wide;
        do_reset();
        wr(8'h21, 8'h7F);
        irq16 = 16'h8000;
        tick(); tick();
        n_tests++; if (int16 !== 1'b1) begin n_fail++; $display("FAIL wide_int: got %b want 1", int16); end
        inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (vec16 !== 8'h17) begin n_fail++; $display("FAIL wide_vec: got %h want 17", vec16); end
        n_tests++; if (st16 !== 32'h8000_0000) begin n_fail++; $display("FAIL wide_status: got %h want 80000000", st16); end
        wr(8'h25, 8'h6F);
        n_tests++; if (st16 !== 32'h0000_0000) begin n_fail++; $display("FAIL wide_seoi: got %h want 00000000", st16); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        wr(8'h20, 8'hFE);
        irq8 = 8'h01;
        tick();
        irq8 = 8'h00;
        tick();
        n_tests++; if (int8 !== 1'b1) begin n_fail++; $display("FAIL b2b_int: got %b want 1", int8); end
        irq8 = 8'h01; inta = 1'b1;
        tick();
        inta = 1'b0;
        n_tests++; if (st8 !== 32'h0001_0001) begin n_fail++; $display("FAIL b2b_edge_wins: got %h want 00010001", st8); end
    endtask

    task automatic test_reset_mid;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (st8 !== 32'h0) begin n_fail++; $display("FAIL mid_status: got %h want 0", st8); end
        n_tests++; if ({int8, vec8} !== 9'h0) begin n_fail++; $display("FAIL mid_outputs: got %h want 000", {int8, vec8}); end
        tick();
        n_tests++; if (st8 !== 32'h0000_0001) begin n_fail++; $display("FAIL mid_held_edge: got %h want 00000001", st8); end
        tick();
        n_tests++; if (int8 !== 1'b0) begin n_fail++; $display("FAIL mid_masked: got %b want 0", int8); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nested();
        test_level();
        test_spurious();
        test_wide();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
